// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges ALU and queued load results into one register-bank write per cycle
module reg_writeback_ctrl #(
    parameter int DW         = 8,
    parameter int AW         = 3,
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3,
    localparam int CW        = $clog2(LQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [AW-1:0]     alu_rd_i,
    input  logic [DW-1:0]     alu_dat_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [AW-1:0]     ld_rd_i,
    input  logic [DW-1:0]     ld_dat_i,
    output logic [AW-1:0]     rd_o,
    output logic [DW-1:0]     dat_o,
    output logic              we_o,
    output logic [2**AW-1:0]  pend_o,
    output logic [CW-1:0]     lq_count_o
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [AW-1:0]       q_rd  [LQ_DEPTH];
    logic [DW-1:0]       q_dat [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] q_vld;
    logic [PW-1:0]       head, tail;
    logic [SW-1:0]       starve;
    logic                empty, push, pop;
    assign empty       = lq_count_o == '0;
    assign ld_ready_o  = cen & (lq_count_o != CW'(LQ_DEPTH));
    assign alu_ready_o = cen & alu_valid_i & !pend_o[alu_rd_i] & (empty | (starve < SW'(STARVE_MAX)));
    assign push        = ld_valid_i & ld_ready_o;
    assign pop         = cen & !alu_ready_o & !empty;
    always_comb begin
        pend_o = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if (q_vld[i]) pend_o[q_rd[i]] = 1'b1;
    end
    always_ff @(posedge clk)
        if (push) begin
            q_rd[tail]  <= ld_rd_i;
            q_dat[tail] <= ld_dat_i;
        end
    always_ff @(posedge clk) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            q_vld      <= '0;
            lq_count_o <= '0;
            starve     <= '0;
            we_o       <= 1'b0;
            rd_o       <= '0;
            dat_o      <= '0;
        end else begin
            we_o       <= alu_ready_o | pop;
            lq_count_o <= lq_count_o + CW'(push) - CW'(pop);
            if (alu_ready_o) begin
                rd_o  <= alu_rd_i;
                dat_o <= alu_dat_i;
            end else if (pop) begin
                rd_o  <= q_rd[head];
                dat_o <= q_dat[head];
            end
            // push and pop never share a slot: that needs full (no push) or empty (no pop)
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            if (cen)
                starve <= (pop | empty) ? '0 :
                          (alu_ready_o && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
        end
    end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: directed and random stimulus against a queue-based reference model
module tb_reg_writeback_ctrl;
    logic       clk = 1'b0;
    logic       rst, cen;
    logic       alu_valid_i, ld_valid_i;
    logic       alu_ready_o, ld_ready_o, we_o;
    logic [2:0] alu_rd_i, ld_rd_i, rd_o;
    logic [7:0] alu_dat_i, ld_dat_i, dat_o, pend_o;
    logic [2:0] lq_count_o;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;
    typedef struct packed {logic [2:0] rd; logic [7:0] dat;} ent_t;
    ent_t       q[$];
    int         starve = 0;
    bit         m_we = 0;
    logic [2:0] m_rd = '0;
    logic [7:0] m_dat = '0;
    always #5 clk = ~clk;
    reg_writeback_ctrl dut (
        .clk(clk), .rst(rst), .cen(cen),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_dat_i(alu_dat_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_dat_i(ld_dat_i),
        .rd_o(rd_o), .dat_o(dat_o), .we_o(we_o), .pend_o(pend_o), .lq_count_o(lq_count_o)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // One clock cycle: drive, check combinational outputs, clock, advance model, check the write port.
    task automatic step(input bit c, input bit r, input bit av, input logic [2:0] ard, input logic [7:0] adat,
                        input bit lv, input logic [2:0] lrd, input logic [7:0] ldat);
        bit win, pop, lrdy, push, was_empty;
        logic [7:0] pend;
        cen = c; rst = r;
        alu_valid_i = av; alu_rd_i = ard; alu_dat_i = adat;
        ld_valid_i = lv; ld_rd_i = lrd; ld_dat_i = ldat;
        #1;
        pend = '0;
        foreach (q[i]) pend[q[i].rd] = 1'b1;
        was_empty = q.size() == 0;
        lrdy = c && q.size() < 4;
        win  = c && av && !pend[ard] && (was_empty || starve < 3);
        pop  = c && !win && !was_empty;
        push = lv && lrdy;
        chk("alu_ready", alu_ready_o, win);
        chk("ld_ready", ld_ready_o, lrdy);
        chk("pend", pend_o, pend);
        chk("count", lq_count_o, q.size());
        @(posedge clk);
        #1;
        if (!r) begin
            q.delete();
            starve = 0; m_we = 0; m_rd = '0; m_dat = '0;
        end else if (c) begin
            if (win) begin
                m_we = 1; m_rd = ard; m_dat = adat;
            end else if (pop) begin
                m_we = 1; m_rd = q[0].rd; m_dat = q[0].dat;
                void'(q.pop_front());
            end else m_we = 0;
            if (push) q.push_back({lrd, ldat});
            starve = (pop || was_empty) ? 0 : win ? ((starve + 1 > 3) ? 3 : starve + 1) : starve;
        end else m_we = 0;
        chk("we", we_o, m_we);
        chk("rd", rd_o, m_rd);
        chk("dat", dat_o, m_dat);
    endtask
    initial begin
        int grants;
        rst = 0; cen = 0; alu_valid_i = 0; ld_valid_i = 0;
        alu_rd_i = '0; alu_dat_i = '0; ld_rd_i = '0; ld_dat_i = '0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3, 8'hA5, 0, 0, 0);
        chk("t1_we", we_o, 1); chk("t1_rd", rd_o, 3); chk("t1_dat", dat_o, 8'hA5);
        step(1, 1, 1, 0, 8'h10, 1, 1, 8'h11);
        step(1, 1, 1, 6, 8'h16, 1, 2, 8'h22);
        step(1, 1, 1, 7, 8'h17, 1, 4, 8'h44);
        step(1, 1, 1, 3, 8'h13, 1, 5, 8'h55);
        chk("t2_count", lq_count_o, 4); chk("t2_pend", pend_o, 8'h36); chk("t2_ldrdy", ld_ready_o, 0);
        step(1, 1, 0, 0, 0, 1, 7, 8'h77);
        chk("t6_nopush", lq_count_o, 3); chk("t2_w1", rd_o, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0); chk("t2_w2", rd_o, 2);
        step(1, 1, 0, 0, 0, 0, 0, 0); chk("t2_w4", rd_o, 4);
        step(1, 1, 0, 0, 0, 0, 0, 0); chk("t2_w5", rd_o, 5);
        step(1, 1, 0, 0, 0, 0, 0, 0); chk("t2_idle", we_o, 0);
        step(1, 1, 1, 0, 8'h01, 1, 2, 8'hD2);
        step(1, 1, 1, 2, 8'hAA, 0, 0, 0);
        chk("t3_load_first", dat_o, 8'hD2);
        step(1, 1, 1, 2, 8'hAA, 0, 0, 0);
        chk("t3_alu_second", dat_o, 8'hAA); chk("t3_rd", rd_o, 2);
        grants = 0;
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 8'(i), 1, 6, 8'(8'h60 + i));
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 0, 8'(8'h80 + i), 0, 0, 0);
            if (we_o && dat_o[7]) grants++;
        end
        chk("t4_alu_grants", grants, 6);
        step(1, 1, 1, 1, 8'hC0, 1, 3, 8'h33);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'hC1, 1, 4, 8'h44);
        chk("t5_we_off", we_o, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 8'(8'hD0 + i), 0, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 1, 1, 8'h21);
        step(1, 1, 1, 6, 0, 1, 2, 8'h22);
        step(1, 1, 1, 7, 0, 1, 3, 8'h23);
        step(1, 1, 1, 5, 0, 1, 4, 8'h24);
        step(1, 1, 0, 0, 0, 1, 7, 8'h27);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_count", lq_count_o, 0); chk("t6_pend", pend_o, 0); chk("t6_we", we_o, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_no_write", we_o, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(9) != 0, $urandom_range(49) != 0,
                 $urandom_range(9) < 7, 3'($urandom), 8'($urandom),
                 $urandom_range(1), 3'($urandom), 8'($urandom));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
